// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : RV32I opcode constants and instruction format classes
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_U   = 3'd2,
        FMT_J   = 3'd3,
        FMT_B   = 3'd4,
        FMT_R   = 3'd5,
        FMT_BAD = 3'd6
    } fmt_e;

    function automatic fmt_e classify(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            OP_BRANCH:                fmt = FMT_B;
            OP_REG:                   fmt = FMT_R;
            default:                  fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// ---------------------------------------------------------------------------
// imm_pack : combinational RV32I field/immediate packer with optional range
//            check (enabled by IMM_ENCODER_RANGE_CHECK_EN)
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module imm_pack
    import riscv_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    logic range_i_s_bad;
    logic range_b_bad;
    logic range_j_bad;
    logic range_u_bad;

    // A value fits when every bit above the field's sign bit matches it.
    assign range_i_s_bad = !((&imm[31:11]) || !(|imm[31:11]));
    assign range_b_bad   = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
    assign range_j_bad   = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
    assign range_u_bad   = |imm[11:0];
`endif

    always_comb begin
        instr = 32'd0;
        err   = 1'b0;
        case (fmt)
            FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_U: instr = {imm[31:12], rd, opcode};
            FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
            FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            default: begin
                instr = 32'd0;
                err   = 1'b1;
            end
        endcase
`ifdef IMM_ENCODER_RANGE_CHECK_EN
        case (fmt)
            FMT_I, FMT_S: err = range_i_s_bad;
            FMT_B:        err = range_b_bad;
            FMT_J:        err = range_j_bad;
            FMT_U:        err = range_u_bad;
            default:      ;
        endcase
`endif
    end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder : 2-stage valid/ready RV32I instruction encoder with saturating
//               error counter; range checking under IMM_ENCODER_RANGE_CHECK_EN
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module imm_encoder
    import riscv_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic        s1_valid;
    logic        s2_valid;
    fmt_e        s1_fmt;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [2:0]  s1_funct3;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;
    logic        advance;
    logic [31:0] pack_instr;
    logic        pack_err;

    assign advance   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || advance;
    assign out_valid = s2_valid;

    imm_pack u_pack (
        .fmt    (s1_fmt),
        .opcode (s1_opcode),
        .rd     (s1_rd),
        .funct3 (s1_funct3),
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .funct7 (s1_funct7),
        .imm    (s1_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= pack_instr;
                    out_err   <= pack_err;
                end
            end
            if (s2_valid && out_ready && out_err && (err_count != '1)) begin
                err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Payload registers only matter while s1_valid is set, so they skip reset.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_fmt    <= classify(in_opcode);
            s1_opcode <= in_opcode;
            s1_rd     <= in_rd;
            s1_funct3 <= in_funct3;
            s1_rs1    <= in_rs1;
            s1_rs2    <= in_rs2;
            s1_funct7 <= in_funct7;
            s1_imm    <= in_imm;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder : directed, self-checking bench for imm_encoder
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imm_encoder;

    localparam int CW  = 3;
    localparam int F_I = 0, F_S = 1, F_U = 2, F_J = 3, F_B = 4, F_R = 5, F_BAD = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [2:0]    in_funct3 = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_instr;
    logic          out_err;
    logic [CW-1:0] err_count;

    int n_chk  = 0;
    int n_fail = 0;
    int n_xfer = 0;
    logic [31:0] last_word;

    imm_encoder #(.ERR_CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_funct3 (in_funct3),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } beat_t;

    beat_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int fmt_of(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: return F_I;
            7'b0100011:                         return F_S;
            7'b0110111, 7'b0010111:             return F_U;
            7'b1101111:                         return F_J;
            7'b1100011:                         return F_B;
            7'b0110011:                         return F_R;
            default:                            return F_BAD;
        endcase
    endfunction

    // Immediate a standard RV32I decoder recovers from a word.
    function automatic logic [31:0] dec_imm(input logic [31:0] w, input int f);
        case (f)
            F_I:     return {{20{w[31]}}, w[31:20]};
            F_S:     return {{20{w[31]}}, w[31:25], w[11:7]};
            F_B:     return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            F_U:     return {w[31:12], 12'd0};
            F_J:     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    // Value the format can actually carry for a requested immediate.
    function automatic logic [31:0] exp_imm(input logic [31:0] v, input int f);
        case (f)
            F_I, F_S: return {{20{v[11]}}, v[11:0]};
            F_B:      return {{19{v[12]}}, v[12:1], 1'b0};
            F_U:      return {v[31:12], 12'd0};
            F_J:      return {{11{v[20]}}, v[20:1], 1'b0};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic exp_err(input beat_t b);
        int f;
        f = fmt_of(b.op);
        if (f == F_BAD) return 1'b1;
`ifdef IMM_ENCODER_RANGE_CHECK_EN
        if (f != F_R) return (b.imm != exp_imm(b.imm, f));
`endif
        return 1'b0;
    endfunction

    task automatic check_beat(input beat_t b);
        int f;
        f = fmt_of(b.op);
        if (f == F_BAD) begin
            chk("bad_instr", out_instr, 32'd0);
            chk("bad_err", {31'd0, out_err}, 32'd1);
        end else begin
            chk("opcode", {25'd0, out_instr[6:0]}, {25'd0, b.op});
            if (f != F_R)
                chk("imm", dec_imm(out_instr, f), exp_imm(b.imm, f));
            if (f == F_I || f == F_U || f == F_J || f == F_R)
                chk("rd", {27'd0, out_instr[11:7]}, {27'd0, b.rd});
            if (f == F_I || f == F_S || f == F_B || f == F_R) begin
                chk("funct3", {29'd0, out_instr[14:12]}, {29'd0, b.f3});
                chk("rs1", {27'd0, out_instr[19:15]}, {27'd0, b.rs1});
            end
            if (f == F_S || f == F_B || f == F_R)
                chk("rs2", {27'd0, out_instr[24:20]}, {27'd0, b.rs2});
            if (f == F_R)
                chk("funct7", {25'd0, out_instr[31:25]}, {25'd0, b.f7});
            chk("err", {31'd0, out_err}, {31'd0, exp_err(b)});
        end
    endtask

    // Compare process: scoreboard of accepted beats, error counter model.
    int          mcnt = 0;
    logic        stall = 1'b0;
    logic [31:0] stall_word;
    logic        stall_err;

    always @(negedge clk) begin
        beat_t nb;
        if (rst) begin
            q.delete();
            mcnt  = 0;
            stall = 1'b0;
        end else begin
            chk("err_count", {{(32-CW){1'b0}}, err_count}, mcnt);
            if (stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_instr", out_instr, stall_word);
                chk("stall_err", {31'd0, out_err}, {31'd0, stall_err});
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check_beat(q[0]);
                    if (out_ready) begin
                        if (exp_err(q[0]) && mcnt < (1 << CW) - 1) mcnt++;
                        void'(q.pop_front());
                        n_xfer++;
                    end
                end
            end
            stall      = out_valid && !out_ready;
            stall_word = out_instr;
            stall_err  = out_err;
            if (in_valid && in_ready) begin
                nb.op = in_opcode; nb.rd = in_rd; nb.f3 = in_funct3;
                nb.rs1 = in_rs1; nb.rs2 = in_rs2; nb.f7 = in_funct7; nb.imm = in_imm;
                q.push_back(nb);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [6:0] f7, input logic [31:0] imm);
        int n;
        in_opcode = op; in_rd = rd; in_funct3 = f3; in_rs1 = rs1;
        in_rs2 = rs2; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the next output beat from an otherwise empty pipeline.
    task automatic wait_out(input string name, input logic [31:0] word, input logic err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) begin
            chk({name, "_timeout"}, {31'd0, out_valid}, 32'd1);
        end else begin
            chk({name, "_latency"}, n, 32'd2);
            chk({name, "_word"}, out_instr, word);
            chk({name, "_err"}, {31'd0, out_err}, {31'd0, err});
        end
        last_word = out_instr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        logic big_err;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_err_count", {{(32-CW){1'b0}}, err_count}, 32'd0);
        @(posedge clk);
        #1;

        // Unused rs2/funct7 carry junk that must not leak into the word.
        send(7'h13, 5'd1, 3'd0, 5'd0, 5'd31, 7'h7F, 32'd5);
        wait_out("addi", 32'h00500093, 1'b0);
        send(7'h23, 5'd31, 3'b010, 5'd1, 5'd2, 7'h55, 32'd8);
        wait_out("sw", 32'h0020A423, 1'b0);
        send(7'h63, 5'd9, 3'b000, 5'd0, 5'd0, 7'h11, 32'hFFFF_FFFC);
        wait_out("beq", 32'hFE000EE3, 1'b0);
        send(7'h6F, 5'd1, 3'd7, 5'd7, 5'd7, 7'h7F, 32'h0000_0800);
        wait_out("jal", 32'h001000EF, 1'b0);
        chk("jal_roundtrip", dec_imm(last_word, F_J), 32'h0000_0800);
        send(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'hDEAD_BEEF);
        wait_out("sub", 32'h402081B3, 1'b0);
        send(7'h37, 5'd5, 3'd3, 5'd9, 5'd9, 7'h01, 32'h1234_5000);
        wait_out("lui", 32'h123452B7, 1'b0);
        send(7'h7F, 5'd3, 3'd5, 5'd4, 5'd6, 7'h12, 32'h0000_1234);
        wait_out("bad_op", 32'h0000_0000, 1'b1);

`ifdef IMM_ENCODER_RANGE_CHECK_EN
        big_err = 1'b1;
`else
        big_err = 1'b0;
`endif
        send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd2048);
        wait_out("addi_2048", 32'h80000093, big_err);

        // Counter saturation at all-ones.
        for (int i = 0; i < 9; i++)
            send(7'h00, 5'(i), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("err_sat", {{(32-CW){1'b0}}, err_count}, 32'd7);
        @(posedge clk);
        #1;

        // Back-to-back stream with a 3-cycle consumer stall.
        start = n_xfer;
        fork
            for (int i = 0; i < 10; i++) begin
                case (i % 5)
                    0: send(7'h13, 5'(i + 1), 3'd0, 5'(i), 5'd0, 7'd0, 32'(i * 3 - 7));
                    1: send(7'h23, 5'd0, 3'b010, 5'(i), 5'(i + 2), 7'd0, 32'(-i * 4));
                    2: send(7'h63, 5'd0, 3'b001, 5'(i), 5'(i + 1), 7'd0, 32'(i * 8 - 32));
                    3: send(7'h37, 5'(i), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i << 12));
                    default: send(7'h6F, 5'(i), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i * 256 - 1024));
                endcase
            end
            for (int c = 0; c < 16; c++) begin
                out_ready = (c < 3) || (c > 5);
                @(posedge clk);
                #1;
            end
        join
        out_ready = 1'b1;
        for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
        #1;
        chk("b2b_count", n_xfer - start, 32'd10);

        // Reset with both stages full and handshakes pending.
        out_ready = 1'b0;
        send(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        send(7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd9);
        in_opcode = 7'h13; in_imm = 32'd77; in_valid = 1'b1;
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_err_count", {{(32-CW){1'b0}}, err_count}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        wait_out("post_rst", 32'h00500093, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of saturating immediate-error counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock; only clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  field bundle valid.
REQ-005 SHALL have port in_ready  output  1  encoder accepts bundle this cycle.
REQ-006 SHALL have ports in_opcode[6:0], in_rd[4:0], in_funct3[2:0], in_rs1[4:0], in_rs2[4:0], in_funct7[6:0]  input  instruction fields.
REQ-007 SHALL have port in_imm  input  32  full signed byte-offset/value immediate (same value the decoder produces).
REQ-008 SHALL have port out_valid  output  1  encoded instruction valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts.
REQ-010 SHALL have port out_instr  output  32  packed RV32I instruction word.
REQ-011 SHALL have port out_err  output  1  immediate not representable or opcode unsupported, aligned with out_instr.
REQ-012 SHALL have port err_count  output  ERR_CNT_W  saturating count of transferred beats with out_err=1.

Function
REQ-013 SHALL classify opcode: 0010011/0000011/1100111 I; 0100011 S; 0110111/0010111 U; 1101111 J; 1100011 B; 0110011 R; other = unsupported.
REQ-014 SHALL pack exactly the inverse bit placement of the immediate decoder: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; U imm[31:12]->[31:12]; B imm[12|10:5]->[31|30:25], imm[4:1|11]->[11:8|7]; J imm[20|10:1|11|19:12]->[31|30:21|20|19:12]; R no immediate, funct7->[31:25].
REQ-015 SHALL place only fields the format uses (rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20]); unused field inputs ignored.
REQ-016 SHALL emit out_instr=0 and out_err=1 for unsupported opcode.
REQ-017 SHALL be a 2-stage pipeline: S1 registers fields + format class; S2 registers packed word + error; latency 2 cycles from accept to out_valid, throughput 1/cycle.
REQ-018 SHALL advance S2 when ~s2_valid | out_ready; S1 advances into S2 under same condition; in_ready = ~s1_valid | S1 advancing; no beat lost or duplicated under any out_ready pattern.
REQ-019 SHALL hold out_instr/out_err stable while out_valid & ~out_ready.
REQ-020 SHALL increment err_count once per transferred beat (out_valid & out_ready) with out_err=1, saturating at all-ones.

Reset
REQ-021 SHALL on rst clear s1_valid, s2_valid, out_valid, out_err, out_instr, err_count to 0; in_ready=1 the cycle after rst deasserts.
REQ-022 SHALL discard in-flight beats when rst asserts mid-operation; rst dominates simultaneous handshakes.

Configuration
REQ-023 SHALL use macro IMM_ENCODER_RANGE_CHECK_EN.
REQ-024 SHALL, with macro defined, set out_err when: I/S imm[31:11] not all equal; B imm[31:12] not all equal or imm[0]=1; J imm[31:20] not all equal or imm[0]=1; U imm[11:0]!=0; word still packed from truncated bits.
REQ-025 SHALL, without macro, omit range logic: out_err only for unsupported opcode, err_count counts only those.

Structure
REQ-026 SHALL place opcode constants and the format-class enum (FMT_I, FMT_S, FMT_U, FMT_J, FMT_B, FMT_R, FMT_BAD) in shared package riscv_pkg, also used by the decoder.
REQ-027 SHALL implement packing + range check as combinational sub-module imm_pack; pipeline/handshake in imm_encoder.

Verification
REQ-028 addi rd=1 rs1=0 imm=5 -> out_instr=0x00500093, out_err=0, out_valid 2 cycles after accept.
REQ-029 sw rs1=1 rs2=2 funct3=010 imm=8 -> 0x0020A423; beq rs1=0 rs2=0 imm=-4 -> 0xFE000EE3.
REQ-030 jal rd=1 imm=0x800 -> 0x001000EF; round-trip through decoder returns 0x00000800.
REQ-031 addi imm=2048 (macro on) -> out_err=1, err_count 0->1; macro off -> out_err=0, err_count 0.
REQ-032 10 back-to-back bundles, out_ready low cycles 3-5 -> all 10 words in order, no duplicates, outputs stable while stalled.
REQ-033 rst asserted with both stages full -> out_valid=0, err_count=0 next cycle; next accepted bundle emerges 2 cycles later.
